// File: rtl/bg_draw_pkg.sv
// Shared definitions for the background frame renderer: display mode enum,
// default RGB332 colours and frame-count limits.
package bg_draw_pkg;

  // Pixel coordinates and all frame geometry arithmetic are 11 bits wide.
  localparam int COORD_W    = 11;
  localparam int MAX_FRAMES = 8;
  localparam int IDX_W      = $clog2(MAX_FRAMES);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10
  } mode_e;

  // RGB332 colours.
  localparam logic [7:0] DEF_BG_COLOR        = 8'hFF;
  localparam logic [7:0] DEF_FRAME_COLOR     = 8'h00;
  localparam logic [7:0] DEF_HIGHLIGHT_COLOR = 8'hE0;

  // Map the raw mode pins onto a supported mode; unsupported encodings
  // (11, and 10 when chase is not built in) fall back to STATIC.
  function automatic mode_e decode_mode(input logic [1:0] raw, input logic chase_en);
    mode_e m;
    case (raw)
      2'b01:   m = MODE_BLINK;
      2'b10:   m = chase_en ? MODE_CHASE : MODE_STATIC;
      default: m = MODE_STATIC;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/frame_hit_detect.sv
// Combinational hit test for a single concentric frame k. The frame box is
// [o, X-o] x [o, Y-o] with o = BRACKET_OFFSET + K*FRAME_SPACING; a pixel hits
// when it is inside the box and within BORDER_WIDTH of one of its edges.
// Degenerate frames (2*o reaching either frame size) never hit.
module frame_hit_detect import bg_draw_pkg::*; #(
  parameter int K              = 0,
  parameter int X_FRAME_SIZE   = 635,
  parameter int Y_FRAME_SIZE   = 475,
  parameter int BRACKET_OFFSET = 30,
  parameter int FRAME_SPACING  = 10,
  parameter int BORDER_WIDTH   = 1
) (
  input  logic [COORD_W-1:0] i_pixel_x,
  input  logic [COORD_W-1:0] i_pixel_y,
  output logic               o_hit
);

  // Geometry is folded to constants; everything wraps at 11 bits.
  localparam logic [COORD_W-1:0] OFS     = COORD_W'(BRACKET_OFFSET + K * FRAME_SPACING);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(X_FRAME_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(Y_FRAME_SIZE);
  localparam logic [COORD_W-1:0] BW      = COORD_W'(BORDER_WIDTH);
  localparam logic [COORD_W-1:0] TWO_OFS = {OFS[COORD_W-2:0], 1'b0};
  localparam logic [COORD_W-1:0] RIGHT   = X_MAX - OFS;
  localparam logic [COORD_W-1:0] BOTTOM  = Y_MAX - OFS;
  localparam logic [COORD_W-1:0] IN_LIM  = OFS + BW;
  localparam logic               DEGEN   = (TWO_OFS >= X_MAX) || (TWO_OFS >= Y_MAX);

  logic          w_inside;
  logic          w_near_edge;
  logic [COORD_W:0] w_x_plus_bw;
  logic [COORD_W:0] w_y_plus_bw;

  // Edge proximity on the far sides is tested as p + BW > edge to avoid
  // an underflowing subtraction.
  always_comb begin
    w_x_plus_bw = {1'b0, i_pixel_x} + {1'b0, BW};
    w_y_plus_bw = {1'b0, i_pixel_y} + {1'b0, BW};
    w_inside    = (i_pixel_x >= OFS) && (i_pixel_x <= RIGHT) &&
                  (i_pixel_y >= OFS) && (i_pixel_y <= BOTTOM);
    w_near_edge = (i_pixel_x < IN_LIM) || (w_x_plus_bw > {1'b0, RIGHT}) ||
                  (i_pixel_y < IN_LIM) || (w_y_plus_bw > {1'b0, BOTTOM});
    o_hit       = !DEGEN && w_inside && w_near_edge;
  end

endmodule

// File: rtl/bg_frames_draw.sv
// Background renderer drawing NUM_FRAMES concentric rectangular frames with
// STATIC, BLINK and (optionally) CHASE animation. Two-stage pipeline from
// pixel coordinates to registered colour/flags.
// Optional feature macro: BG_FRAMES_CHASE_EN compiles in CHASE mode, the
// chase index register and highlight colouring; without it mode 10 is STATIC.
module bg_frames_draw import bg_draw_pkg::*; #(
  parameter int         X_FRAME_SIZE    = 635,
  parameter int         Y_FRAME_SIZE    = 475,
  parameter int         BRACKET_OFFSET  = 30,
  parameter int         NUM_FRAMES      = 3,
  parameter int         FRAME_SPACING   = 10,
  parameter int         BORDER_WIDTH    = 1,
  parameter int         BLINK_PERIOD    = 30,
  parameter logic [7:0] BG_COLOR        = DEF_BG_COLOR,
  parameter logic [7:0] FRAME_COLOR     = DEF_FRAME_COLOR,
  parameter logic [7:0] HIGHLIGHT_COLOR = DEF_HIGHLIGHT_COLOR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               startOfFrame,
  input  logic [1:0]         mode,
  output logic [7:0]         BG_RGB,
  output logic               bordersDrawReq,
  output logic [IDX_W-1:0]   frameIdx
);

`ifdef BG_FRAMES_CHASE_EN
  localparam logic CHASE_EN = 1'b1;
`else
  localparam logic CHASE_EN = 1'b0;
`endif

  localparam logic [7:0]       TICK_LAST  = 8'(BLINK_PERIOD - 1);
  localparam logic [IDX_W-1:0] CHASE_LAST = IDX_W'(NUM_FRAMES - 1);

  logic [NUM_FRAMES-1:0] w_hit;
  logic [NUM_FRAMES-1:0] r_hit;
  mode_e                 w_next_mode;
  mode_e                 r_active_mode;
  logic [7:0]            r_tick_cnt;
  logic                  w_tick;
  logic                  r_blink_on;
  logic                  w_any;
  logic [IDX_W-1:0]      w_idx;
  logic [7:0]            w_rgb;

  // One hit detector per frame; geometry is resolved at elaboration.
  for (genvar k = 0; k < NUM_FRAMES; k++) begin : g_frame
    frame_hit_detect #(
      .K              (k),
      .X_FRAME_SIZE   (X_FRAME_SIZE),
      .Y_FRAME_SIZE   (Y_FRAME_SIZE),
      .BRACKET_OFFSET (BRACKET_OFFSET),
      .FRAME_SPACING  (FRAME_SPACING),
      .BORDER_WIDTH   (BORDER_WIDTH)
    ) u_hit (
      .i_pixel_x (pixelX),
      .i_pixel_y (pixelY),
      .o_hit     (w_hit[k])
    );
  end

  assign w_next_mode = decode_mode(mode, CHASE_EN);
  assign w_tick      = startOfFrame && (r_tick_cnt == TICK_LAST);

  // Video-frame counter; the wrap pulse is the animation tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (startOfFrame) begin
      r_tick_cnt <= w_tick ? 8'd0 : r_tick_cnt + 8'd1;
    end
  end

  // Latch mode only at frame start; blink phase sits at 1 outside BLINK and
  // a coincident tick acts on the newly latched mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active_mode <= MODE_STATIC;
      r_blink_on    <= 1'b1;
    end else if (startOfFrame) begin
      r_active_mode <= w_next_mode;
      if (w_next_mode != MODE_BLINK) begin
        r_blink_on <= 1'b1;
      end else if (w_tick) begin
        r_blink_on <= ~r_blink_on;
      end
    end
  end

`ifdef BG_FRAMES_CHASE_EN
  logic [IDX_W-1:0] r_chase_idx;

  // Highlighted frame index, advancing on each tick while in CHASE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chase_idx <= '0;
    end else if (startOfFrame) begin
      if (w_next_mode != MODE_CHASE) begin
        r_chase_idx <= '0;
      end else if (w_tick) begin
        r_chase_idx <= (r_chase_idx == CHASE_LAST) ? '0 : r_chase_idx + 1'b1;
      end
    end
  end
`else
  logic w_unused_chase;
  assign w_unused_chase = ^{HIGHLIGHT_COLOR, CHASE_LAST};
`endif

  // Stage 1: capture the per-frame hit vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit <= '0;
    end else begin
      r_hit <= w_hit;
    end
  end

  // Lowest-index frame wins; colour depends on the animation state, while
  // the hit flag and index depend on geometry alone.
  always_comb begin
    w_any = |r_hit;
    w_idx = '0;
    for (int k = NUM_FRAMES - 1; k >= 0; k--) begin
      if (r_hit[k]) w_idx = IDX_W'(k);
    end
    w_rgb = BG_COLOR;
    if (w_any) begin
      w_rgb = FRAME_COLOR;
      if ((r_active_mode == MODE_BLINK) && !r_blink_on) w_rgb = BG_COLOR;
`ifdef BG_FRAMES_CHASE_EN
      if ((r_active_mode == MODE_CHASE) && (w_idx == r_chase_idx)) w_rgb = HIGHLIGHT_COLOR;
`endif
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      BG_RGB         <= BG_COLOR;
      bordersDrawReq <= 1'b0;
      frameIdx       <= '0;
    end else begin
      BG_RGB         <= w_rgb;
      bordersDrawReq <= w_any;
      frameIdx       <= w_idx;
    end
  end

endmodule

// File: tb/tb_bg_frames_draw.sv
// Bench for bg_frames_draw: a default-parameter instance plus an 8-frame,
// 30-pixel-spacing instance sharing pixel/reset stimulus. Expected outputs
// come from a geometric reference model and an animation-state model.
module tb_bg_frames_draw;
  import bg_draw_pkg::*;

  localparam int NF = 3, SP = 10, BO = 30, XS = 635, YS = 475, BW = 1, BP = 30;
  localparam int NF_B = 8, SP_B = 30;

`ifdef BG_FRAMES_CHASE_EN
  localparam bit CHASE_EN = 1'b1;
`else
  localparam bit CHASE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [10:0] pixel_x = '0;
  logic [10:0] pixel_y = '0;
  logic        sof = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [1:0]  mode_b = 2'b00;
  logic [7:0]  rgb_a, rgb_b;
  logic        req_a, req_b;
  logic [2:0]  idx_a, idx_b;

  bg_frames_draw dut_a (
    .clk(clk), .reset(reset), .pixelX(pixel_x), .pixelY(pixel_y),
    .startOfFrame(sof), .mode(mode),
    .BG_RGB(rgb_a), .bordersDrawReq(req_a), .frameIdx(idx_a)
  );

  bg_frames_draw #(.NUM_FRAMES(NF_B), .FRAME_SPACING(SP_B)) dut_b (
    .clk(clk), .reset(reset), .pixelX(pixel_x), .pixelY(pixel_y),
    .startOfFrame(sof), .mode(mode_b),
    .BG_RGB(rgb_b), .bordersDrawReq(req_b), .frameIdx(idx_b)
  );

  // ---------------- reference model ----------------
  int m_tc, m_blink, m_chase, m_mode;   // m_mode: 0 static, 1 blink, 2 chase
  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_b_q[$];

  function automatic int ref_hit(input int x, input int y, input int nf, input int sp);
    for (int k = 0; k < nf; k++) begin
      int o, r, b;
      o = (BO + k * sp) % 2048;
      if (((2 * o) % 2048) >= XS || ((2 * o) % 2048) >= YS) continue;
      r = XS - o;
      b = YS - o;
      if (x >= o && x <= r && y >= o && y <= b &&
          (x < o + BW || x + BW > r || y < o + BW || y + BW > b)) return k;
    end
    return -1;
  endfunction

  function automatic logic [11:0] ref_out_a(input int x, input int y);
    int k;
    logic [7:0] c;
    k = ref_hit(x, y, NF, SP);
    if (k < 0) return {8'hFF, 1'b0, 3'd0};
    c = 8'h00;
    if (m_mode == 1 && m_blink == 0) c = 8'hFF;
    if (m_mode == 2 && k == m_chase) c = 8'hE0;
    return {c, 1'b1, 3'(k)};
  endfunction

  function automatic logic [11:0] ref_out_b(input int x, input int y);
    int k;
    k = ref_hit(x, y, NF_B, SP_B);
    if (k < 0) return {8'hFF, 1'b0, 3'd0};
    return {8'h00, 1'b1, 3'(k)};
  endfunction

  task automatic model_reset();
    m_tc = 0; m_blink = 1; m_chase = 0; m_mode = 0;
  endtask

  // Effect of one startOfFrame pulse with the current mode pins.
  task automatic model_sof();
    int nm;
    bit tick;
    nm = (mode == 2'b01) ? 1 : ((mode == 2'b10 && CHASE_EN) ? 2 : 0);
    tick = (m_tc == BP - 1);
    m_tc = tick ? 0 : m_tc + 1;
    if (nm != 1) m_blink = 1;
    else if (tick) m_blink = 1 - m_blink;
    if (nm != 2) m_chase = 0;
    else if (tick) m_chase = (m_chase + 1) % NF;
    m_mode = nm;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1;
      step();
      model_sof();
      sof = 1'b0;
    end
  endtask

  // Apply a pixel, wait the two-cycle latency, compare both instances.
  task automatic check_pixel(input string tag, input int x, input int y);
    logic [11:0] e, o;
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    exp_q.push_back(ref_out_a(x, y));
    exp_b_q.push_back(ref_out_b(x, y));
    step();
    step();
    e = exp_q.pop_front();
    o = {rgb_a, req_a, idx_a};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s (%0d,%0d): observed rgb=%h req=%b idx=%0d, expected rgb=%h req=%b idx=%0d",
             tag, x, y, o[11:4], o[3], o[2:0], e[11:4], e[3], e[2:0]);
    end
    e = exp_b_q.pop_front();
    o = {rgb_b, req_b, idx_b};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s_nf8 (%0d,%0d): observed rgb=%h req=%b idx=%0d, expected rgb=%h req=%b idx=%0d",
             tag, x, y, o[11:4], o[3], o[2:0], e[11:4], e[3], e[2:0]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [11:0] o;
    o = {rgb_a, req_a, idx_a};
    vectors++;
    assert (o === {8'hFF, 1'b0, 3'd0}) else begin
      miscompares++;
      $error("FAIL %s: observed rgb=%h req=%b idx=%0d, expected rgb=ff req=0 idx=0",
             tag, o[11:4], o[3], o[2:0]);
    end
    o = {rgb_b, req_b, idx_b};
    vectors++;
    assert (o === {8'hFF, 1'b0, 3'd0}) else begin
      miscompares++;
      $error("FAIL %s_nf8: observed rgb=%h req=%b idx=%0d, expected rgb=ff req=0 idx=0",
             tag, o[11:4], o[3], o[2:0]);
    end
  endtask

  // Pick a pixel near some frame edge (including degenerate candidates).
  task automatic rand_edge_pixel(input int sp, output int x, output int y);
    int k, o;
    k = $urandom_range(0, 7);
    o = BO + k * sp;
    case ($urandom_range(0, 4))
      0: begin x = o;      y = $urandom_range(0, 480); end
      1: begin x = XS - o; y = $urandom_range(0, 480); end
      2: begin y = o;      x = $urandom_range(0, 640); end
      3: begin y = YS - o; x = $urandom_range(0, 640); end
      default: begin x = o + $urandom_range(0, 2); y = o + $urandom_range(0, 2); end
    endcase
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int x, y;
    model_reset();

    // Reset state, with a frame pixel and a coincident startOfFrame applied.
    reset = 1'b1; sof = 1'b1; pixel_x = 11'd30; pixel_y = 11'd200;
    step(); step(); step();
    check_reset_state("reset_state");
    sof = 1'b0;
    reset = 1'b0;
    model_reset();

    // STATIC geometry.
    check_pixel("static_f0", 30, 200);
    check_pixel("static_f1", 40, 200);
    check_pixel("static_gap", 35, 200);
    check_pixel("static_f2", 50, 200);
    check_pixel("static_nof3", 60, 200);
    check_pixel("static_right0", 605, 200);
    check_pixel("static_top0", 200, 30);
    check_pixel("static_bot0", 200, 445);
    check_pixel("static_out", 606, 200);
    check_pixel("static_origin", 0, 0);
    check_pixel("degen_f7", 240, 240);
    check_pixel("nf8_f6", 210, 240);

    // BLINK: off after one period, back on after another.
    mode = 2'b01;
    pulse_sof(30);
    check_pixel("blink_off_f0", 30, 200);
    check_pixel("blink_off_f1", 40, 200);
    pulse_sof(30);
    check_pixel("blink_on_f0", 30, 200);
    check_pixel("blink_on_f2", 50, 200);

    // Mode change mid-frame has no effect until the next frame start.
    pulse_sof(30);
    mode = 2'b00;
    check_pixel("midframe_hold", 30, 200);
    pulse_sof(1);
    check_pixel("midframe_apply", 30, 200);

    // Reset in BLINK with blink off.
    mode = 2'b01;
    pulse_sof(BP - m_tc);
    check_pixel("preset_blink_off", 40, 200);
    reset = 1'b1; sof = 1'b1; pixel_x = 11'd30; pixel_y = 11'd200;
    step(); step();
    check_reset_state("reset_mid_blink");
    sof = 1'b0; mode = 2'b00; reset = 1'b0;
    model_reset();
    check_pixel("post_reset_static", 30, 200);
    mode = 2'b01;
    pulse_sof(29);
    check_pixel("tick_restart_29", 30, 200);
    pulse_sof(1);
    check_pixel("tick_restart_30", 30, 200);

    // CHASE (STATIC when not built in).
    mode = 2'b10;
    for (int r = 0; r < 4; r++) begin
      pulse_sof(30);
      check_pixel("chase_f0", 30, 200);
      check_pixel("chase_f1", 40, 200);
      check_pixel("chase_f2", 50, 200);
    end
    mode = 2'b00;
    pulse_sof(1);
    check_pixel("chase_exit", 30, 200);

    // Randomized mode/pulse/pixel mix.
    for (int r = 0; r < 40; r++) begin
      mode = 2'($urandom_range(0, 3));
      pulse_sof($urandom_range(0, 40));
      rand_edge_pixel(SP, x, y);
      check_pixel("rand_edge_a", x, y);
      rand_edge_pixel(SP_B, x, y);
      check_pixel("rand_edge_b", x, y);
      check_pixel("rand_any", $urandom_range(0, 700), $urandom_range(0, 520));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
